// File: rtl/blackbox_prober_pkg.sv
// Shared definitions for the blackbox prober: sequencer state encoding,
// default sweep parameters and a helper that sizes the settle timer.
package blackbox_prober_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam int DEF_N_IN          = 3;
  localparam int DEF_SETTLE_CYCLES = 1;

  // Width needed to hold settle_cycles-1; never narrower than one bit.
  function automatic int timer_width(input int settle_cycles);
    return (settle_cycles <= 1) ? 1 : $clog2(settle_cycles);
  endfunction

endpackage

// File: rtl/blackbox_prober_settle_timer.sv
// settle_timer: loadable down-counter that times how long a vector is held
// on the blackbox inputs before its output is sampled.
//   clock, reset_n : clock and asynchronous active-low reset
//   load           : load count_in (takes priority over counting)
//   count_in       : value loaded; expired rises count_in cycles later
//   expired        : high while the counter sits at zero
module settle_timer #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] count_in,
  output logic         expired
);

  logic [W-1:0] count;

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values; blocking = here would create order-dependent simulation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= count_in;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/blackbox_prober.sv
// blackbox_prober: sweeps every input vector of an N_IN-input combinational
// blackbox in ascending order, holds each for SETTLE_CYCLES cycles, samples
// the blackbox output and builds its truth table, then compares it against a
// golden table.
//   clock, reset_n  : clock and asynchronous active-low reset
//   start           : begin a sweep (accepted only in IDLE)
//   abort           : cancel a running sweep; partial results are kept
//   expected        : golden table, bit i = expected output for vector i
//   bb_out          : blackbox output
//   bb_in           : registered vector driven to the blackbox
//   busy            : high while vectors are being applied/sampled
//   done            : one-cycle pulse when a sweep completes
//   truth_table     : captured outputs, bit i = bb_out for bb_in == i
//   mismatch        : at least one captured bit differs from expected
//   mismatch_count  : number of differing bits
//   first_mismatch  : lowest differing vector index (0 if none)
module blackbox_prober
  import blackbox_prober_pkg::*;
#(
  parameter int N_IN          = DEF_N_IN,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 bb_out,
  output logic [N_IN-1:0]      bb_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   truth_table,
  output logic                 mismatch,
  output logic [N_IN:0]        mismatch_count,
  output logic [N_IN-1:0]      first_mismatch
);

  localparam int              TW       = timer_width(SETTLE_CYCLES);
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(2**N_IN - 1);
  localparam logic [TW-1:0]   SETTLE_M1 = TW'(SETTLE_CYCLES - 1);

  state_t state;
  logic   timer_load;
  logic   timer_expired;
  logic   miss;

  // The timer is reloaded on every edge that enters APPLY, so it is already
  // counting during the first APPLY cycle.
  assign timer_load = !abort &&
                      (((state == ST_IDLE)   && start) ||
                       ((state == ST_SAMPLE) && (bb_in != LAST_IDX)));

  assign miss = (bb_out != expected[bb_in]);

  settle_timer #(.W(TW)) u_settle_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (timer_load),
    .count_in (SETTLE_M1),
    .expired  (timer_expired)
  );

  // bb_in doubles as the sweep index: it is exactly the vector being applied.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      bb_in          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      truth_table    <= '0;
      mismatch       <= 1'b0;
      mismatch_count <= '0;
      first_mismatch <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            state          <= ST_APPLY;
            bb_in          <= '0;
            busy           <= 1'b1;
            truth_table    <= '0;
            mismatch       <= 1'b0;
            mismatch_count <= '0;
            first_mismatch <= '0;
          end
        end
        ST_APPLY: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            bb_in <= '0;
          end else if (timer_expired) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            bb_in <= '0;
          end else begin
            truth_table[bb_in] <= bb_out;
            if (miss) begin
              // Cannot overflow: at most 2**N_IN misses per sweep.
              mismatch_count <= mismatch_count + (N_IN+1)'(1);
              if (!mismatch) begin
                first_mismatch <= bb_in;
                mismatch       <= 1'b1;
              end
            end
            if (bb_in == LAST_IDX) begin
              state <= ST_FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
              bb_in <= '0;
            end else begin
              state <= ST_APPLY;
              bb_in <= bb_in + N_IN'(1);
            end
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
